// File: rtl/fft_bitrev_reorder_if.sv
// Sample-pair bus for the bit-reversal reorder stage: one sync flag plus two
// packed complex samples (real in the upper half, imag in the lower half).
interface fft_bitrev_reorder_if #(
    parameter int WIDTH = 34
);
    logic             sync;
    logic [WIDTH-1:0] data_0;
    logic [WIDTH-1:0] data_1;

    modport master (
        output sync,
        output data_0,
        output data_1
    );

    modport slave (
        input sync,
        input data_0,
        input data_1
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Final-stage FFT output reorder: takes sample pairs in bit-reversed order and
// re-emits them in natural order through a ping-pong buffer.
//
// state        | meaning
// S_WAIT_SYNC  | not locked, inputs discarded until the first sync
// S_FILL       | locked, writing the first frame, nothing to read yet
// S_STREAM     | one bank filling while the completed bank is read out
module fft_bitrev_reorder #(
    parameter int LGSIZE = 12,
    parameter int WIDTH  = 34
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clk_enable,
    fft_bitrev_reorder_if.slave       in_bus,
    fft_bitrev_reorder_if.master      out_bus
);
    localparam int AW   = LGSIZE - 1;
    localparam int HALF = 1 << AW;

    typedef enum logic [1:0] {
        S_WAIT_SYNC,
        S_FILL,
        S_STREAM
    } state_t;

    state_t state, state_next;

    logic [AW-1:0]    wr_cnt;
    logic             wr_bank;
    logic             wr_en;
    logic             frame_end;

    logic [AW-1:0]    rd_addr;
    logic             rd_bank;
    logic             rd_valid_a;
    logic             rd_sync_a;

    logic [WIDTH-1:0] rd_data_0;
    logic [WIDTH-1:0] rd_data_1;
    logic             rd_valid_b;
    logic             rd_sync_b;

    logic [WIDTH-1:0] out_0_q;
    logic [WIDTH-1:0] out_1_q;
    logic             out_sync_q;

    // Bank select is the address MSB, so each half is one 2*N/2-word RAM.
    logic [WIDTH-1:0] mem_0 [0:2*HALF-1];
    logic [WIDTH-1:0] mem_1 [0:2*HALF-1];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    assign frame_end = (wr_cnt == {AW{1'b1}});

    // State register; reset clears lock regardless of enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_WAIT_SYNC;
        end else if (i_clk_enable) begin
            state <= state_next;
        end
    end

    // Lock / fill / stream sequencing; later syncs are deliberately ignored.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        case (state)
            S_WAIT_SYNC: begin
                if (in_bus.sync) begin
                    wr_en      = 1'b1;
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                wr_en = 1'b1;
                if (frame_end) begin
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                wr_en = 1'b1;
            end
            default: begin
                state_next = S_WAIT_SYNC;
            end
        endcase
    end

    // Write counter and bank select; the bank flips as the last pair lands.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (i_clk_enable && wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (frame_end) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Both halves share the bit-reversed address: pair m holds X[brev(m)] and X[brev(m)+N/2].
    always_ff @(posedge i_clk) begin
        if (i_clk_enable && wr_en && !i_reset) begin
            mem_0[{wr_bank, bitrev(wr_cnt)}] <= in_bus.data_0;
            mem_1[{wr_bank, bitrev(wr_cnt)}] <= in_bus.data_1;
        end
    end

    // Read address stage: k follows the write counter, bank captured with it
    // so the swap edge cannot redirect an in-flight read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_addr    <= '0;
            rd_bank    <= 1'b0;
            rd_valid_a <= 1'b0;
            rd_sync_a  <= 1'b0;
        end else if (i_clk_enable) begin
            rd_addr    <= wr_cnt;
            rd_bank    <= ~wr_bank;
            rd_valid_a <= (state == S_STREAM);
            rd_sync_a  <= (state == S_STREAM) && (wr_cnt == '0);
        end
    end

    // Registered memory read; data has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_clk_enable) begin
            rd_data_0 <= mem_0[{rd_bank, rd_addr}];
            rd_data_1 <= mem_1[{rd_bank, rd_addr}];
        end
    end

    // Valid/sync tracking alongside the memory read register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_valid_b <= 1'b0;
            rd_sync_b  <= 1'b0;
        end else if (i_clk_enable) begin
            rd_valid_b <= rd_valid_a;
            rd_sync_b  <= rd_sync_a;
        end
    end

    // Output register; stale or uninitialised memory is masked to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_0_q    <= '0;
            out_1_q    <= '0;
            out_sync_q <= 1'b0;
        end else if (i_clk_enable) begin
            out_0_q    <= rd_valid_b ? rd_data_0 : '0;
            out_1_q    <= rd_valid_b ? rd_data_1 : '0;
            out_sync_q <= rd_sync_b;
        end
    end

    assign out_bus.data_0 = out_0_q;
    assign out_bus.data_1 = out_1_q;
    assign out_bus.sync   = out_sync_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench: LGSIZE=3 tagged frames (lock, sync re-assert, enable gaps,
// mid-readout reset) plus three random LGSIZE=12 frames.
module tb_fft_bitrev_reorder;
    localparam int S_LG = 3;
    localparam int S_W  = 8;
    localparam int B_LG = 12;
    localparam int B_W  = 34;
    localparam int B_HALF = 1 << (B_LG - 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic s_reset, s_en;
    logic b_reset, b_en;

    fft_bitrev_reorder_if #(.WIDTH(S_W)) s_in ();
    fft_bitrev_reorder_if #(.WIDTH(S_W)) s_out ();
    fft_bitrev_reorder_if #(.WIDTH(B_W)) b_in ();
    fft_bitrev_reorder_if #(.WIDTH(B_W)) b_out ();

    fft_bitrev_reorder #(.LGSIZE(S_LG), .WIDTH(S_W)) dut_small (
        .i_clk        (clk),
        .i_reset      (s_reset),
        .i_clk_enable (s_en),
        .in_bus       (s_in),
        .out_bus      (s_out)
    );

    fft_bitrev_reorder #(.LGSIZE(B_LG), .WIDTH(B_W)) dut_big (
        .i_clk        (clk),
        .i_reset      (b_reset),
        .i_clk_enable (b_en),
        .in_bus       (b_in),
        .out_bus      (b_out)
    );

    int checks   = 0;
    int failures = 0;

    logic [B_W-1:0] xs [3][4096];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hand-derived expectation for the N=8 stream: nothing until enabled
    // edge 6 after sync, then (k, k+4) per edge with sync on k=0.
    function automatic logic [16:0] small_exp(input int e, input int base);
        logic [16:0] r;
        int j, f, k;
        r = '0;
        if (e >= 6) begin
            j = e - 6;
            f = j / 4;
            k = j % 4;
            r = {(k == 0), 8'(base + f*16 + k), 8'(base + f*16 + k + 4)};
        end
        return r;
    endfunction

    task automatic small_edge(input bit en, input bit sync, input logic [7:0] d0, input logic [7:0] d1);
        s_en        = en;
        s_in.sync   = sync;
        s_in.data_0 = d0;
        s_in.data_1 = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic small_check(input string tag, input logic [16:0] exp);
        check_val({tag, "_sync"}, 64'(s_out.sync),   64'(exp[16]));
        check_val({tag, "_out0"}, 64'(s_out.data_0), 64'(exp[15:8]));
        check_val({tag, "_out1"}, 64'(s_out.data_1), 64'(exp[7:0]));
    endtask

    // Streams bit-reversed pairs (0,4),(2,6),(1,5),(3,7) per frame.
    task automatic run_small(input int n_edges, input bit gaps, input int extra_sync, input int base);
        int nat0 [4] = '{0, 2, 1, 3};
        logic [15:0] pat = 16'b1001_1101_0110_1001;
        int e = 0;
        int guard = 0;
        while (e < n_edges && guard < 1000) begin
            bit en;
            int f, m;
            en = gaps ? pat[guard % 16] : 1'b1;
            guard++;
            f = e / 4;
            m = e % 4;
            small_edge(en, (e == 0) || (e == extra_sync),
                       8'(base + f*16 + nat0[m]), 8'(base + f*16 + nat0[m] + 4));
            if (en) begin
                small_check(gaps ? "gap_stream" : "stream", small_exp(e, base));
                e++;
            end else begin
                small_check("gap_hold", small_exp(e - 1, base));
            end
        end
        check_val("run_complete", 64'(e), 64'(n_edges));
    endtask

    function automatic int brev12(input int v);
        int r = 0;
        for (int i = 0; i < B_LG; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (B_LG - 1 - i));
        end
        return r;
    endfunction

    initial begin
        b_reset = 1'b1; b_en = 1'b0;
        b_in.sync = 1'b0; b_in.data_0 = '0; b_in.data_1 = '0;
        s_reset = 1'b1; s_en = 1'b1;
        s_in.sync = 1'b0; s_in.data_0 = '0; s_in.data_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        small_check("reset", 17'h0);
        s_reset = 1'b0;

        // Garbage before any sync must not lock or write.
        for (int i = 0; i < 5; i++) begin
            small_edge(1'b1, 1'b0, 8'($urandom), 8'($urandom));
            small_check("prelock", 17'h0);
        end

        // Four output frames, with a stray sync at m=2 of the second frame.
        run_small(22, 1'b0, 6, 0);

        // Same stream with enable gaps after a fresh reset.
        s_reset = 1'b1;
        small_edge(1'b1, 1'b0, 8'h0, 8'h0);
        s_reset = 1'b0;
        small_check("reset2", 17'h0);
        run_small(22, 1'b1, -1, 64);

        // Reset (with enable low) in the middle of the second frame's readout.
        s_reset = 1'b1;
        small_edge(1'b1, 1'b0, 8'h0, 8'h0);
        s_reset = 1'b0;
        run_small(12, 1'b0, -1, 0);
        s_reset = 1'b1;
        small_edge(1'b0, 1'b0, 8'h0, 8'h0);
        s_reset = 1'b0;
        small_check("midreset", 17'h0);
        run_small(22, 1'b0, -1, 128);

        // LGSIZE=12: three random frames back to back, one filler frame to flush.
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 4096; n++) begin
                xs[f][n] = B_W'({$urandom, $urandom});
            end
        end
        s_en = 1'b0;
        b_en = 1'b1;
        @(posedge clk);
        #1;
        check_val("big_reset_sync", 64'(b_out.sync), 64'd0);
        check_val("big_reset_out0", 64'(b_out.data_0), 64'd0);
        b_reset = 1'b0;
        for (int e = 0; e < 2050 + 3*B_HALF; e++) begin
            int f, m, idx, j, ff, k;
            f   = (e / B_HALF) % 3;
            m   = e % B_HALF;
            idx = brev12(2*m);
            b_in.sync   = (e == 0);
            b_in.data_0 = xs[f][idx];
            b_in.data_1 = xs[f][idx + B_HALF];
            @(posedge clk);
            #1;
            if (e < B_HALF + 2) begin
                check_val("big_pre_sync", 64'(b_out.sync), 64'd0);
                check_val("big_pre_out0", 64'(b_out.data_0), 64'd0);
                check_val("big_pre_out1", 64'(b_out.data_1), 64'd0);
            end else begin
                j  = e - (B_HALF + 2);
                ff = j / B_HALF;
                k  = j % B_HALF;
                check_val("big_sync", 64'(b_out.sync), 64'(k == 0));
                check_val("big_out0", 64'(b_out.data_0), 64'(xs[ff][k]));
                check_val("big_out1", 64'(b_out.data_1), 64'(xs[ff][k + B_HALF]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
